// File: rtl/chroni_vram_if.sv
// Bus bundle between chroni_vram and its users: chroni video fetch port,
// CPU req/ack port and write-buffer status.
interface chroni_vram_if #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              vid_active;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_data;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              wfifo_full;
   logic [CNT_W-1:0]  wfifo_count;

   modport master (
      output vid_active, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  vid_data, cpu_ack, cpu_rdata, wfifo_full, wfifo_count
   );

   modport slave (
      input  vid_active, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output vid_data, cpu_ack, cpu_rdata, wfifo_full, wfifo_count
   );
endinterface

// File: rtl/chroni_vram.sv
// Single-port video RAM for chroni: video fetch has absolute priority, CPU
// writes are buffered in a FIFO and retired in idle cycles, CPU reads wait.
module chroni_vram #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         vga_clk,
   input  logic         reset_n,
   chroni_vram_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [DATA_W-1:0] mem_q       [DEPTH];
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              ack_q, ack_d;
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] vid_data_q, vid_data_d;

   logic              push, pop, rd_go;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;

   // One read port: video owns it while active, otherwise the pending CPU read.
   assign mem_raddr = bus.vid_active ? bus.vid_addr : raddr_q;
   assign mem_rdata = mem_q[mem_raddr];

   always_comb begin
      push  = bus.cpu_req & bus.cpu_we & ~ack_q & ~full_q;
      pop   = ~bus.vid_active & (count_q != '0);
      rd_go = (state_q == S_WAIT) & ~bus.vid_active & (count_q == '0);

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)
         count_d = count_q + CNT_W'(1);
      else if (!push && pop)
         count_d = count_q - CNT_W'(1);
      full_d = (count_d == CNT_W'(FIFO_DEPTH));

      state_d = state_q;
      raddr_d = raddr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req && !bus.cpu_we && !ack_q) begin
               state_d = S_WAIT;
               raddr_d = bus.cpu_addr;
            end
         end
         S_WAIT:  if (rd_go) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ack_d      = push | rd_go;
      rdata_d    = rd_go ? mem_rdata : rdata_q;
      vid_data_d = bus.vid_active ? mem_rdata : vid_data_q;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         ack_q      <= 1'b0;
         state_q    <= S_IDLE;
         raddr_q    <= '0;
         rdata_q    <= '0;
         vid_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         ack_q      <= ack_d;
         state_q    <= state_d;
         raddr_q    <= raddr_d;
         rdata_q    <= rdata_d;
         vid_data_q <= vid_data_d;
      end
   end

   // Storage has no reset: memory survives reset, stale FIFO slots are unreachable.
   always_ff @(posedge vga_clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.cpu_addr;
         fifo_data_q[wr_ptr_q] <= bus.cpu_wdata;
      end
      if (pop)
         mem_q[fifo_addr_q[rd_ptr_q]] <= fifo_data_q[rd_ptr_q];
   end

   assign bus.vid_data    = vid_data_q;
   assign bus.cpu_ack     = ack_q;
   assign bus.cpu_rdata   = rdata_q;
   assign bus.wfifo_full  = full_q;
   assign bus.wfifo_count = count_q;
endmodule
